// File: rtl/ram_arb2.sv
// Two-master round-robin arbiter with lock/burst support in front of one single-port SRAM.
// Drives the active-low SRAM controls and returns registered read data to the owning master.
module ram_arb2 #(
    parameter int AddressWidth = 11,
    parameter int DataWidth    = 144,
    parameter int MaxLock      = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    m0_req,
    input  logic                    m0_lock,
    input  logic                    m0_we,
    input  logic [AddressWidth-1:0] m0_addr,
    input  logic [DataWidth-1:0]    m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DataWidth-1:0]    m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_lock,
    input  logic                    m1_we,
    input  logic [AddressWidth-1:0] m1_addr,
    input  logic [DataWidth-1:0]    m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DataWidth-1:0]    m1_rdata,
    output logic [AddressWidth-1:0] A,
    output logic [DataWidth-1:0]    D,
    output logic                    CEN,
    output logic                    WEN,
    output logic                    OEN,
    input  logic [DataWidth-1:0]    Q
);

    localparam int CntWidth = $clog2(MaxLock + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxLock);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // last_r: 1'b0 = M0 granted last, 1'b1 = M1 granted last
    logic                last_r, last_s;
    owner_t              owner_r, owner_s;
    logic [CntWidth-1:0] lock_cnt_r, lock_cnt_s;
    logic                m0_rvalid_r, m1_rvalid_r;
    logic                starved_s, gnt0_s, gnt1_s;

    // Lock holder has used up its quota while the other master waits
    always_comb begin
        starved_s = 1'b0;
        case (owner_r)
            OWN_M0:   starved_s = (lock_cnt_r == CntMax) && m1_req;
            OWN_M1:   starved_s = (lock_cnt_r == CntMax) && m0_req;
            OWN_NONE: starved_s = 1'b0;
            default:  starved_s = 1'b0;
        endcase
    end

    // Grant selection: starvation override, then lock hold, then round-robin
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (RST) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (starved_s) begin
            gnt0_s = (owner_r == OWN_M1);
            gnt1_s = (owner_r == OWN_M0);
        end else if ((owner_r == OWN_M0) && m0_req) begin
            gnt0_s = 1'b1;
        end else if ((owner_r == OWN_M1) && m1_req) begin
            gnt1_s = 1'b1;
        end else if (m0_req && m1_req) begin
            gnt0_s = last_r;
            gnt1_s = ~last_r;
        end else if (m0_req) begin
            gnt0_s = 1'b1;
        end else if (m1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Arbitration state update on accepted access or owner release
    always_comb begin
        last_s     = last_r;
        owner_s    = owner_r;
        lock_cnt_s = lock_cnt_r;
        if (gnt0_s) begin
            last_s = 1'b0;
            if (m0_lock) begin
                owner_s = OWN_M0;
                if ((owner_r == OWN_M0) && m1_req) begin
                    lock_cnt_s = (lock_cnt_r == CntMax) ? lock_cnt_r : lock_cnt_r + CntWidth'(1);
                end else begin
                    lock_cnt_s = {CntWidth{1'b0}};
                end
            end else begin
                owner_s    = OWN_NONE;
                lock_cnt_s = {CntWidth{1'b0}};
            end
        end else if (gnt1_s) begin
            last_s = 1'b1;
            if (m1_lock) begin
                owner_s = OWN_M1;
                if ((owner_r == OWN_M1) && m0_req) begin
                    lock_cnt_s = (lock_cnt_r == CntMax) ? lock_cnt_r : lock_cnt_r + CntWidth'(1);
                end else begin
                    lock_cnt_s = {CntWidth{1'b0}};
                end
            end else begin
                owner_s    = OWN_NONE;
                lock_cnt_s = {CntWidth{1'b0}};
            end
        end else begin
            // No grant outside reset means nobody requests, so any owner has let go
            owner_s    = OWN_NONE;
            lock_cnt_s = {CntWidth{1'b0}};
        end
    end

    // State and read-return registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_r      <= 1'b1;
            owner_r     <= OWN_NONE;
            lock_cnt_r  <= {CntWidth{1'b0}};
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
        end else begin
            last_r      <= last_s;
            owner_r     <= owner_s;
            lock_cnt_r  <= lock_cnt_s;
            m0_rvalid_r <= gnt0_s & ~m0_we;
            m1_rvalid_r <= gnt1_s & ~m1_we;
        end
    end

    // SRAM command mux from the granted master
    always_comb begin
        CEN = 1'b1;
        WEN = 1'b1;
        A   = {AddressWidth{1'b0}};
        D   = {DataWidth{1'b0}};
        if (gnt0_s) begin
            CEN = 1'b0;
            WEN = ~m0_we;
            A   = m0_addr;
            D   = m0_wdata;
        end else if (gnt1_s) begin
            CEN = 1'b0;
            WEN = ~m1_we;
            A   = m1_addr;
            D   = m1_wdata;
        end else begin
            CEN = 1'b1;
            WEN = 1'b1;
            A   = {AddressWidth{1'b0}};
            D   = {DataWidth{1'b0}};
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;
    assign OEN       = ~(m0_rvalid_r | m1_rvalid_r);
    assign m0_rdata  = m0_rvalid_r ? Q : {DataWidth{1'b0}};
    assign m1_rdata  = m1_rvalid_r ? Q : {DataWidth{1'b0}};

endmodule

// File: doc/ram_arb2.md
# ram_arb2

Two-requester arbiter and sequencer for the single-port behavioural SRAM used across the ASIP (address/data/CEN/WEN/OEN macro, one-cycle registered read). It sits between two masters, e.g. the core load/store unit (M0) and the DMA/key-loader engine (M1), and one SRAM instance. It grants at most one access per cycle with round-robin fairness and an optional lock for atomic read-modify-write or burst sequences. A lock-hold limit prevents starvation. It drives the RAM's active-low controls and routes registered read data back to the owning master with a valid strobe.

## Interface
- AddressWidth, 11, RAM address width
- DataWidth, 144, RAM word width
- MaxLock, 8, max consecutive locked grants to one master while the other is requesting (≥1)
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- m0_req / m1_req  input  1  access request, held until accepted
- m0_lock / m1_lock  input  1  request to keep ownership on following cycles
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_addr / m1_addr  input  AddressWidth  access address
- m0_wdata / m1_wdata  input  DataWidth  write data
- m0_gnt / m1_gnt  output  1  combinational grant; access accepted at the edge where req & gnt
- m0_rvalid / m1_rvalid  output  1  registered; read data valid this cycle
- m0_rdata / m1_rdata  output  DataWidth  read data, equal to Q when the matching rvalid is high, else 0
- A  output  AddressWidth  RAM address
- D  output  DataWidth  RAM write data
- CEN  output  1  RAM chip enable, active-low
- WEN  output  1  RAM write enable, 0 = write, 1 = read
- OEN  output  1  RAM output enable, active-low
- Q  input  DataWidth  RAM read data

## Operation
- State:
  - `last`: 1 bit, last granted master.
  - `owner`: none, M0 or M1, the lock holder.
  - `lock_cnt`: counter 0..MaxLock.
  - `rd_pend`: 1 bit, read issued last cycle.
  - `rd_sel`: 1 bit, which master issued that read.
- Arbitration, combinational, with at most one gnt high:
  - If `owner` = Mx and mx_req = 1 and not starved, grant Mx.
  - Otherwise, if exactly one req is high, grant that master.
  - If both reqs are high, grant the master ≠ `last`.
- Starved: `lock_cnt` = MaxLock and the other master's req = 1. In that case the other master is granted, `owner` clears, and `lock_cnt` resets to 0.
- On an accepted access by Mx:
  - `last` ← x.
  - If mx_lock = 1, `owner` ← Mx. If `owner` was already Mx and the other req = 1, `lock_cnt` increments, saturating at MaxLock. Otherwise `lock_cnt` ← 0.
  - If mx_lock = 0, `owner` ← none and `lock_cnt` ← 0.
- If the owner drops req, `owner` ← none and `lock_cnt` ← 0 in that cycle. Normal round-robin applies in the same cycle.
- RAM drive, combinational from the granted master:
  - CEN = 0.
  - WEN = ~we.
  - A = addr.
  - D = wdata.
- With no grant: CEN = 1, WEN = 1, A = 0, D = 0.
- Read return: an accepted read sets `rd_pend` = 1 and `rd_sel` = x for the next cycle. In that cycle OEN = 0, mx_rvalid = 1 and mx_rdata = Q. Otherwise OEN = 1.
- Writes produce no response.

## Timing
- Reset values:
  - Outputs: all gnt 0, all rvalid 0, all rdata 0, CEN = 1, WEN = 1, OEN = 1, A = 0, D = 0.
  - State: `last` = M1 (so M0 wins the first tie), `owner` = none, `lock_cnt` = 0, `rd_pend` = 0.
- Grant latency: 0 cycles; gnt is valid in the same cycle as req.
- Read latency: data is at the master 1 cycle after the accepting edge.
- Throughput: one access per cycle. Back-to-back reads give rvalid on consecutive cycles and may alternate masters.
- Write then read of the same address on the next cycle returns the new data.
- Simultaneous req from both masters with no owner: strict alternation.
- RST asserted mid-operation:
  - Immediately clears `rd_pend`, rvalid, `owner` and `lock_cnt`.
  - An in-flight read is lost; masters must reissue.
  - CEN is forced to 1 while RST is high.

## Test plan
- Reset: hold RST, drive m0_req = 1 → CEN = 1, gnt = 0, OEN = 1. Release → m0_gnt = 1 in the same cycle, `last` = M0 after the edge.
- Write/read: M0 writes 0x1A5 to addr 5, then reads addr 5 → m0_rvalid = 1 one cycle after the read grant, m0_rdata = 0x1A5, OEN = 0 in that cycle only, m1_rvalid = 0.
- Round-robin: both masters hold req with no lock for 6 cycles → grants M0, M1, M0, M1, M0, M1; each rvalid follows its own read by 1 cycle with the correct data.
- Lock: M1 reads with lock = 1 and M0 idle for 4 cycles → M1 granted every cycle. M1 drops req → M0 is granted in the same cycle once it requests.
- Starvation: MaxLock = 3, M0 holds lock + req, M1 requests throughout → M0 granted 4 cycles (first grant plus 3 counted), then M1 granted, `owner` = none.
- Reset mid-read: RST asserted in the cycle after an accepted read → m0_rvalid = 0 and OEN = 1 immediately, with no spurious rvalid after release.
